// File: rtl/otg_hpi_master.sv
// otg_hpi_master: Avalon-MM to timed HPI bus cycle engine; define OTG_HPI_IRQ_EN for the synchronized sticky interrupt.
module otg_hpi_master #(
  parameter int SETUP_CYCLES   = 1,
  parameter int STROBE_CYCLES  = 4,
  parameter int RECOVER_CYCLES = 2
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        chipselect,
  input  logic        read,
  input  logic        write,
  input  logic [1:0]  address,
  input  logic [31:0] writedata,
  output logic [31:0] readdata,
  output logic        waitrequest,
  output logic [1:0]  otg_addr,
  output logic [15:0] otg_data_out,
  output logic        otg_data_oe,
  input  logic [15:0] otg_data_in,
  output logic        otg_cs_n,
  output logic        otg_rd_n,
  output logic        otg_wr_n,
  input  logic        otg_int,
  output logic        irq
);
  typedef enum logic [2:0] {IDLE, SETUP, STROBE, HOLD, RECOVER, DONE} state_e;
  localparam logic [3:0] SETUP_LD   = 4'(SETUP_CYCLES - 1);
  localparam logic [3:0] STROBE_LD  = 4'(STROBE_CYCLES - 1);
  localparam logic [3:0] RECOVER_LD = 4'(RECOVER_CYCLES - 1);
  state_e      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic        wr_q, wr_d;
  logic [1:0]  addr_q, addr_d;
  logic [15:0] wdata_q, wdata_d, hpi_data_q, hpi_data_d;
  logic [16:0] rdata_q, rdata_d;
  logic        cs_n_q, cs_n_d, rd_n_q, rd_n_d, wr_n_q, wr_n_d, oe_q, oe_d;
  logic        irq_flag_q;
  logic        req, active;
  logic        unused_ok;
  assign req         = chipselect & (read | write);
  assign waitrequest = req & (state_q != DONE);
  assign unused_ok   = ^{writedata[31:16], otg_int};
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q - {3'b0, |cnt_q};
    wr_d       = wr_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    hpi_data_d = hpi_data_q;
    rdata_d    = rdata_q;
    case (state_q)
      IDLE: if (req) begin
        state_d = SETUP;
        cnt_d   = SETUP_LD;
        wr_d    = write;
        addr_d  = address;
        wdata_d = writedata[15:0];
      end
      SETUP: if (cnt_q == 4'd0) begin
        state_d = STROBE;
        cnt_d   = STROBE_LD;
      end
      STROBE: if (cnt_q == 4'd0) begin
        state_d    = HOLD;
        hpi_data_d = wr_q ? hpi_data_q : otg_data_in;
      end
      HOLD: begin
        state_d = RECOVER;
        cnt_d   = RECOVER_LD;
      end
      RECOVER: if (cnt_q == 4'd0) begin
        state_d = DONE;
        rdata_d = wr_q ? rdata_q : {irq_flag_q, hpi_data_q};
      end
      default: state_d = IDLE;
    endcase
    // pins are registered from the next state so they switch glitch-free with the FSM
    active = state_d inside {SETUP, STROBE, HOLD};
    cs_n_d = !active;
    oe_d   = active & wr_d;
    rd_n_d = !(state_d == STROBE && !wr_d);
    wr_n_d = !(state_d == STROBE && wr_d);
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= IDLE;
      cnt_q      <= 4'd0;
      wr_q       <= 1'b0;
      addr_q     <= 2'd0;
      wdata_q    <= 16'd0;
      hpi_data_q <= 16'd0;
      rdata_q    <= 17'd0;
      cs_n_q     <= 1'b1;
      rd_n_q     <= 1'b1;
      wr_n_q     <= 1'b1;
      oe_q       <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      hpi_data_q <= hpi_data_d;
      rdata_q    <= rdata_d;
      cs_n_q     <= cs_n_d;
      rd_n_q     <= rd_n_d;
      wr_n_q     <= wr_n_d;
      oe_q       <= oe_d;
    end
  end
`ifdef OTG_HPI_IRQ_EN
  logic [2:0] sync_q, sync_d;
  logic       irq_flag_d;
  always_comb begin
    sync_d     = {sync_q[1:0], otg_int};
    irq_flag_d = (sync_q[1] & ~sync_q[2]) | (irq_flag_q & ~(state_q == DONE && addr_q == 2'd3));
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q     <= 3'd0;
      irq_flag_q <= 1'b0;
    end else begin
      sync_q     <= sync_d;
      irq_flag_q <= irq_flag_d;
    end
  end
`else
  assign irq_flag_q = 1'b0;
`endif
  assign readdata     = {15'b0, rdata_q};
  assign irq          = irq_flag_q;
  assign otg_addr     = addr_q;
  assign otg_data_out = wdata_q;
  assign otg_data_oe  = oe_q;
  assign otg_cs_n     = cs_n_q;
  assign otg_rd_n     = rd_n_q;
  assign otg_wr_n     = wr_n_q;
endmodule

// File: tb/tb_otg_hpi_master.sv
// tb_otg_hpi_master: timeline model of otg_hpi_master checked every cycle, plus directed literal checks.
module tb_otg_hpi_master;
  localparam int S = 1, T = 4, R = 2, DT = S + T + R + 2;
  logic        clk = 0, reset_n = 1;
  logic        chipselect = 0, read = 0, write = 0;
  logic [1:0]  address = 0;
  logic [31:0] writedata = 0;
  logic [15:0] otg_data_in = 0, din_fixed = 16'hBEEF;
  logic        otg_int = 0, int_fixed = 0, rand_din = 0, rand_int = 0;
  logic [31:0] readdata;
  logic        waitrequest, otg_data_oe, otg_cs_n, otg_rd_n, otg_wr_n, irq;
  logic [1:0]  otg_addr;
  logic [15:0] otg_data_out;
  int checks = 0, failures = 0;
  int t = -1;
  logic        m_wr = 0, m_flag = 0, m_clr = 0, m_set = 0, act, stb;
  logic [1:0]  m_addr = 0;
  logic [15:0] m_wdata = 0, m_cap = 0;
  logic [31:0] m_rdata = 0;
  logic [3:0]  ihist = 0;
  int wr_low = 0, rd_low = 0, oe_hi = 0, cs_low = 0, hi_run = 0, last_gap = 0;

  always #5 clk = ~clk;

  otg_hpi_master dut (
    .clk(clk), .reset_n(reset_n), .chipselect(chipselect), .read(read), .write(write),
    .address(address), .writedata(writedata), .readdata(readdata), .waitrequest(waitrequest),
    .otg_addr(otg_addr), .otg_data_out(otg_data_out), .otg_data_oe(otg_data_oe),
    .otg_data_in(otg_data_in), .otg_cs_n(otg_cs_n), .otg_rd_n(otg_rd_n), .otg_wr_n(otg_wr_n),
    .otg_int(otg_int), .irq(irq)
  );

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s got=%h exp=%h at %0t", n, a, e, $time);
    end
  endtask

  always @(posedge clk) begin
    #2;
    otg_data_in = rand_din ? 16'($urandom) : din_fixed;
    otg_int = rand_int ? (($urandom_range(0, 7) == 0) ? ~otg_int : otg_int) : int_fixed;
  end

  // t counts cycles since the request was sampled: 1..S SETUP, then STROBE, HOLD, RECOVER, DONE at DT
  always @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      t = -1; m_wr = 0; m_addr = 0; m_wdata = 0; m_cap = 0; m_rdata = 0; m_flag = 0; ihist = 0;
    end else begin
      m_clr = (t == DT) && (m_addr == 2'd3);
      if (t == S + T && !m_wr) m_cap = otg_data_in;
      if (t == DT - 1 && !m_wr) m_rdata = {15'b0, m_flag, m_cap};
`ifdef OTG_HPI_IRQ_EN
      m_set = ihist[1] && !ihist[2];
      m_flag = m_set || (m_flag && !m_clr);
      ihist = {ihist[2:0], otg_int};
`endif
      if (t == DT) t = -1;
      else if (t >= 1) t++;
      else if (chipselect && (read || write)) begin
        t = 1; m_wr = write; m_addr = address; m_wdata = writedata[15:0];
      end
    end
  end

  always @(negedge clk) begin
    act = t >= 1 && t <= S + T + 1;
    stb = t >= S + 1 && t <= S + T;
    chk("cs_n", otg_cs_n, !act);
    chk("rd_n", otg_rd_n, !(stb && !m_wr));
    chk("wr_n", otg_wr_n, !(stb && m_wr));
    chk("data_oe", otg_data_oe, act && m_wr);
    chk("addr", otg_addr, m_addr);
    chk("data_out", otg_data_out, m_wdata);
    chk("waitrequest", waitrequest, chipselect && (read || write) && t != DT);
    chk("readdata", readdata, m_rdata);
    chk("irq", irq, m_flag);
    if (!otg_wr_n) wr_low++;
    if (!otg_rd_n) rd_low++;
    if (otg_data_oe) oe_hi++;
    if (!otg_cs_n) cs_low++;
    if (otg_cs_n) hi_run++;
    else begin
      if (hi_run != 0) last_gap = hi_run;
      hi_run = 0;
    end
  end

  task automatic idle(input int n);
    chipselect = 0; read = 0; write = 0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  task automatic access(input logic r, input logic w, input logic [1:0] a, input logic [31:0] d, output int lat);
    chipselect = 1; read = r; write = w; address = a; writedata = d;
    lat = 0;
    forever begin
      @(negedge clk);
      if (!waitrequest) break;
      lat++;
      if (lat == 2) begin address = 2'($urandom); writedata = $urandom; end
      if (lat > 60) begin
        checks++; failures++;
        $display("FAIL access_timeout waitrequest still high after %0d cycles", lat);
        break;
      end
    end
    @(posedge clk); #1;
    chipselect = 0; read = 0; write = 0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat, k, n, b_wr, b_rd, b_oe, b_cs;
    logic r, w;
    #2 reset_n = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_cs_n", otg_cs_n, 1); chk("rst_rd_n", otg_rd_n, 1); chk("rst_wr_n", otg_wr_n, 1);
    chk("rst_oe", otg_data_oe, 0); chk("rst_addr", otg_addr, 0); chk("rst_data_out", otg_data_out, 0);
    chk("rst_readdata", readdata, 0); chk("rst_irq", irq, 0);
    reset_n = 1;
    idle(2);
    b_wr = wr_low; b_oe = oe_hi; b_cs = cs_low;
    access(0, 1, 2, 32'h0000_1234, lat);
    chk("wr_latency", lat, DT); chk("wr_pulse", wr_low - b_wr, T);
    chk("wr_oe_cycles", oe_hi - b_oe, S + T + 1); chk("wr_cs_cycles", cs_low - b_cs, S + T + 1);
    chk("wr_otg_addr", otg_addr, 2); chk("wr_otg_data", otg_data_out, 16'h1234);
    chk("wr_keeps_readdata", readdata, 0);
    idle(2);
    b_rd = rd_low; b_oe = oe_hi;
    access(1, 0, 0, 0, lat);
    chk("rd_latency", lat, DT); chk("rd_pulse", rd_low - b_rd, T);
    chk("rd_oe_cycles", oe_hi - b_oe, 0); chk("rd_readdata", readdata, 32'h0000_BEEF);
    idle(1);
    din_fixed = 16'hCAFE;
    access(0, 1, 0, 32'h0000_00AA, lat);
    access(1, 0, 0, 0, lat);
    chk("b2b_cs_gap", last_gap, R + 2); chk("b2b_latency", lat, DT);
    chk("b2b_readdata", readdata, 32'h0000_CAFE);
    idle(1);
    b_wr = wr_low; b_rd = rd_low;
    access(1, 1, 1, 32'h0000_5A5A, lat);
    chk("both_wr_pulse", wr_low - b_wr, T); chk("both_rd_pulse", rd_low - b_rd, 0);
    chk("both_addr", otg_addr, 1); chk("both_data", otg_data_out, 16'h5A5A);
    idle(1);
    chipselect = 1; write = 1; address = 0; writedata = 32'h0000_0F0F;
    n = 0;
    while (t != S + 2 && n < 20) begin @(negedge clk); n++; end
    chk("pre_rst_wr_n", otg_wr_n, 0);
    #2 reset_n = 0;
    #1;
    chk("midrst_wr_n", otg_wr_n, 1); chk("midrst_cs_n", otg_cs_n, 1); chk("midrst_oe", otg_data_oe, 0);
    chipselect = 0; write = 0;
    @(posedge clk); #1;
    reset_n = 1;
    access(1, 0, 3, 0, lat);
    chk("post_rst_latency", lat, DT); chk("post_rst_readdata", readdata, 32'h0000_CAFE);
    rand_din = 1; rand_int = 1;
    for (int i = 0; i < 150; i++) begin
      k = $urandom_range(0, 2);
      r = (k != 1); w = (k != 0);
      if ($urandom_range(0, 7) == 0) begin
        chipselect = 1; read = r; write = w; address = 2'($urandom); writedata = $urandom;
        repeat ($urandom_range(1, 5)) @(negedge clk);
        @(posedge clk); #1;
        chipselect = 0; read = 0; write = 0;
        n = 0;
        while (t != -1 && n < 30) begin @(posedge clk); #1; n++; end
      end else access(r, w, 2'($urandom), $urandom, lat);
      idle($urandom_range(0, 3));
    end
`ifdef OTG_HPI_IRQ_EN
    rand_int = 0; int_fixed = 0;
    idle(5);
    access(1, 0, 3, 0, lat);
    int_fixed = 1;
    idle(2);
    int_fixed = 0;
    idle(1);
    chk("irq_set", irq, 1);
    access(1, 0, 3, 0, lat);
    chk("irq_read_bit16", readdata[16], 1);
    chk("irq_cleared", irq, 0);
`endif
    idle(3);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
